// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: stage enables/flushes, dmem handshake, hazard FSM.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_op,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t st, st_nx;

    logic uses_rs1, uses_rs2;
    logic redirect, load_use;
    logic mem_wait, hz_ok;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            7'b0110011,
            7'b0100011,
            7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0000011,
            7'b0010011,
            7'b1100111: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign redirect = ex_valid & ex_redirect;
    assign load_use = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                      ((uses_rs1 & (id_rs1 == ex_rd)) |
                       (uses_rs2 & (id_rs2 == ex_rd)));

    // ID/EX only hold bubbles in REDIRECT, so hazards are evaluated elsewhere.
    assign mem_wait = ((st == RUN) & mem_op & ~dmem_ack) |
                      ((st == MEM_WAIT) & ~dmem_ack);
    assign hz_ok    = (st == RUN) | (st == MEM_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= RUN;
        else        st <= st_nx;
    end

    always_comb begin
        st_nx        = RUN;
        dmem_req     = (st == RUN) & mem_op;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (mem_wait) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            st_nx        = MEM_WAIT;
        end else if (hz_ok & redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            st_nx      = REDIRECT;
        end else if (hz_ok & load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (st == REDIRECT) begin
            // Drop the BRAM word fetched from the old path.
            ifid_flush = 1'b1;
        end
        if (!rst_n) begin
            st_nx        = RUN;
            dmem_req     = 1'b0;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end
    end

    assign state = st;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (!pc_en)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (st_nx == REDIRECT)
                redir_cnt <= redir_cnt + CNT_W'(1);
        end
    end
`else
    assign cyc_cnt   = '0;
    assign stall_cnt = '0;
    assign redir_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected controls queued per driven cycle.
// Counter expectations track PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

    localparam int CNT_W = 32;

    // {dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
    localparam logic [7:0] N    = 8'b0_1111_000;
    localparam logic [7:0] NREQ = 8'b1_1111_000;
    localparam logic [7:0] FRZ  = 8'b0_0000_001;
    localparam logic [7:0] FRQ  = 8'b1_0000_001;
    localparam logic [7:0] LU   = 8'b0_0011_010;
    localparam logic [7:0] RD   = 8'b0_1111_110;
    localparam logic [7:0] RD2  = 8'b0_1111_100;
    localparam logic [7:0] RST  = 8'b0_0000_111;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;

    logic clk = 1'b0;
    logic rst_n;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic ex_valid, ex_is_load, ex_redirect, mem_op, dmem_ack;
    logic dmem_req, pc_en, ifid_en, idex_en, exmem_en;
    logic ifid_flush, idex_flush, memwb_bubble;
    logic [1:0] state;
    logic [CNT_W-1:0] cyc_cnt, stall_cnt, redir_cnt;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];
    logic [CNT_W-1:0] m_cyc = '0, m_stall = '0, m_redir = '0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .mem_op(mem_op), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .state(state),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {dmem_req, pc_en, ifid_en, idex_en, exmem_en,
                ifid_flush, idex_flush, memwb_bubble};
    endfunction

    task automatic check_cnt(input string tag);
`ifdef PIPE_CTRL_PERF_EN
        check({tag, ".cyc"}, 64'(cyc_cnt), 64'(m_cyc));
        check({tag, ".stall"}, 64'(stall_cnt), 64'(m_stall));
        check({tag, ".redir"}, 64'(redir_cnt), 64'(m_redir));
`else
        check({tag, ".cnt"}, 64'({cyc_cnt, stall_cnt, redir_cnt}), 64'(0));
`endif
    endtask

    // Called just after a rising edge: drive, queue expectation, check at negedge.
    task automatic cyc(input string tag, input logic [6:0] op,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic ev, input logic ld, input logic [4:0] rd,
                       input logic red, input logic mop, input logic ack,
                       input logic [7:0] ec, input logic [1:0] es,
                       input logic rflag);
        logic [9:0] e;
        id_opcode = op; id_rs1 = r1; id_rs2 = r2;
        ex_valid = ev; ex_is_load = ld; ex_rd = rd;
        ex_redirect = red; mem_op = mop; dmem_ack = ack;
        sb.push_back({ec, es});
        @(negedge clk);
        e = sb.pop_front();
        check({tag, ".ctl"}, 64'(ctl()), 64'(e[9:2]));
        check({tag, ".state"}, 64'(state), 64'(e[1:0]));
        check_cnt(tag);
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_cyc++;
            if (!e[8]) m_stall++;
            if (rflag) m_redir++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        id_opcode = '0; id_rs1 = '0; id_rs2 = '0;
        ex_valid = 0; ex_is_load = 0; ex_rd = '0;
        ex_redirect = 0; mem_op = 0; dmem_ack = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ctl", 64'(ctl()), 64'(RST));
        check("rst.state", 64'(state), 64'(0));
        check_cnt("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc("norm",    OP_R, 1, 2, 0,0,0, 0, 0,0, N,    0, 0);
        cyc("lu_rs1",  OP_R, 5, 1, 1,1,5, 0, 0,0, LU,   0, 0);
        cyc("lu_after",OP_R, 5, 1, 0,0,0, 0, 0,0, N,    0, 0);
        cyc("lu_rs2",  OP_BR,3, 7, 1,1,7, 0, 0,0, LU,   0, 0);
        cyc("x0",      OP_R, 0, 0, 1,1,0, 0, 0,0, N,    0, 0);
        cyc("lui",     OP_LU,5, 5, 1,1,5, 0, 0,0, N,    0, 0);
        cyc("imm_rs2", OP_I, 1, 5, 1,1,5, 0, 0,0, N,    0, 0);
        cyc("exinv",   OP_R, 5, 5, 0,1,5, 0, 0,0, N,    0, 0);
        cyc("mem_ack0",OP_R, 1, 2, 0,0,0, 0, 1,1, NREQ, 0, 0);
        cyc("mw_req",  OP_R, 1, 2, 0,0,0, 0, 1,0, FRQ,  0, 0);
        cyc("mw_1",    OP_R, 1, 2, 0,0,0, 0, 1,0, FRZ,  1, 0);
        cyc("mw_2",    OP_R, 1, 2, 0,0,0, 0, 1,0, FRZ,  1, 0);
        cyc("mw_ack",  OP_R, 1, 2, 0,0,0, 0, 1,1, N,    1, 0);
        cyc("mw_done", OP_R, 1, 2, 0,0,0, 0, 0,0, N,    0, 0);
        cyc("rd_0",    OP_R, 1, 2, 1,0,3, 1, 0,0, RD,   0, 1);
        cyc("rd_1",    OP_R, 1, 2, 1,0,3, 1, 1,0, RD2,  2, 0);
        cyc("rd_2",    OP_R, 1, 2, 0,0,0, 0, 0,0, N,    0, 0);
        cyc("pri_mem", OP_R, 1, 2, 1,0,3, 1, 1,0, FRQ,  0, 0);
        cyc("mwrd_ack",OP_R, 1, 2, 1,0,3, 1, 1,1, RD,   1, 1);
        cyc("mwrd_1",  OP_R, 1, 2, 0,0,0, 0, 0,0, RD2,  2, 0);
        cyc("mwrd_2",  OP_R, 1, 2, 0,0,0, 0, 0,0, N,    0, 0);
        cyc("mwlu_req",OP_R, 1, 2, 0,0,0, 0, 1,0, FRQ,  0, 0);
        cyc("mwlu_ack",OP_R, 4, 2, 1,1,4, 0, 1,1, LU,   1, 0);
        cyc("mwlu_end",OP_R, 4, 2, 0,0,0, 0, 0,0, N,    0, 0);
        cyc("pri_rd",  OP_R, 5, 2, 1,1,5, 1, 0,0, RD,   0, 1);
        cyc("pri_rd1", OP_R, 5, 2, 0,0,0, 0, 0,0, RD2,  2, 0);
        cyc("pri_rd2", OP_R, 5, 2, 0,0,0, 0, 0,0, N,    0, 0);
        cyc("rstw_req",OP_R, 1, 2, 0,0,0, 0, 1,0, FRQ,  0, 0);

        rst_n = 1'b0;
        #1;
        m_cyc = '0; m_stall = '0; m_redir = '0;
        check("rstw.ctl", 64'(ctl()), 64'(RST));
        check("rstw.state", 64'(state), 64'(0));
        check_cnt("rstw");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("post_rst",OP_R, 1, 2, 0,0,0, 0, 0,0, N,    0, 0);
        cyc("post_rs2",OP_R, 1, 2, 0,0,0, 0, 0,0, N,    0, 0);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
